// File: rtl/load_store_unit.sv
// Load/store unit: runs one memory operation at a time over a req/ack data bus,
// producing byte enables, lane-replicated store data and extended load results.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [1:0]  mem_size,
  input  logic        unsigned_value,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic             bus_we_q, bus_we_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [1:0]       err_cause_q, err_cause_d;
  logic             resp_err_q, resp_err_d;

  logic        req;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_shifted;
  logic [31:0] rdata_ext;

  assign req        = mem_r | mem_w;
  assign illegal    = (mem_r & mem_w) | (mem_size == 2'b11);
  assign misaligned = ((mem_size == 2'b01) & addr[0]) |
                      ((mem_size == 2'b10) & (addr[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Addressed byte/half is moved down to bit 0 before extension.
  assign rdata_shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    rdata_ext = rdata_shifted;
    case (size_q)
      2'b00:   rdata_ext = uns_q ? {24'd0, rdata_shifted[7:0]}
                                 : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   rdata_ext = uns_q ? {16'd0, rdata_shifted[15:0]}
                                 : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: rdata_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    err_cause_d = err_cause_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (illegal) begin
            err_cause_d = CAUSE_ILLEGAL;
            resp_err_d  = 1'b1;
            state_d     = S_RESP;
          end else if (misaligned) begin
            err_cause_d = CAUSE_MISALIGN;
            resp_err_d  = 1'b1;
            state_d     = S_RESP;
          end else begin
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_we_d    = mem_w;
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
            size_d      = mem_size;
            uns_d       = unsigned_value;
            off_d       = addr[1:0];
            cnt_d       = '0;
            state_d     = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack in the final timeout cycle still completes the transfer.
        if (bus_ack) begin
          if (!bus_we_q) begin
            load_data_d = rdata_ext;
          end
          resp_err_d = 1'b0;
          state_d    = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          err_cause_d = CAUSE_TIMEOUT;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      load_data_q <= '0;
      err_cause_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      err_cause_q <= err_cause_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Pulses and bus_req decode from state so reset drops them without a clock.
  assign stall     = (state_q != S_IDLE);
  assign bus_req   = (state_q == S_BUS);
  assign done      = (state_q == S_RESP) & ~resp_err_q;
  assign err       = (state_q == S_RESP) & resp_err_q;
  assign load_data = load_data_q;
  assign err_cause = err_cause_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
